// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one-outstanding imem request engine feeding a DEPTH-entry {inst, pc} queue toward ID.
// Latency: request in T, response in T+k (k>=1), entry visible on out_* in T+k+1 at the earliest (no rdata bypass).
// Backpressure: out_ready low lets the queue fill; requests stop once queued + in-flight entries reach DEPTH.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   imem_addr/rmask     fetch address (always fetch_pc) and one-cycle 4'hf request strobe
//   imem_rdata/resp     instruction word and its one-cycle response strobe
//   redirect/_pc        control-flow change from EX; flushes queue, retargets fetch
//   out_valid/ready     handshake toward ID
//   out_inst/pc/pc_next/order   head entry fields for the IF/ID register
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_next,
    output logic [63:0] out_order
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;       // pc of the request currently in flight
    logic          outstanding;
    logic          stale;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [63:0]   order;

    logic [CW:0]   reserved;
    logic          issue;
    logic          push;
    logic          pop;

    // A live in-flight request already owns a queue slot; a stale one does not.
    // Same-cycle dequeues are deliberately not credited, keeping this path short.
    assign reserved = {1'b0, count} + {{CW{1'b0}}, (outstanding && !stale)};

    assign issue = !rst && !redirect && (!outstanding || imem_resp) && (reserved < DEPTH_C);
    assign push  = imem_resp && outstanding && !stale && !redirect;
    assign pop   = out_valid && out_ready;

    assign imem_addr   = fetch_pc;
    assign imem_rmask  = issue ? 4'hf : 4'h0;

    // Redirect masks the head immediately so ID never consumes a wrong-path entry.
    assign out_valid   = (count != '0) && !redirect;
    assign out_inst    = inst_q[head];
    assign out_pc      = pc_q[head];
    assign out_pc_next = pc_q[head] + 32'd4;
    assign out_order   = order;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            stale       <= 1'b0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            order       <= 64'd0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h3;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            if (outstanding && !imem_resp) begin
                // Response still coming for the old path; drop it on arrival.
                stale <= 1'b1;
            end else if (imem_resp) begin
                outstanding <= 1'b0;
                stale       <= 1'b0;
            end
        end else begin
            if (issue) begin
                outstanding <= 1'b1;
                stale       <= 1'b0;
                req_pc      <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end else if (imem_resp) begin
                outstanding <= 1'b0;
                stale       <= 1'b0;
            end

            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head  <= head + PW'(1);
                order <= order + 64'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[tail] <= imem_rdata;
            pc_q[tail]   <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_next;
    logic [63:0] out_order;

    fetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc_next (out_pc_next),
        .out_order   (out_order)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory responder state: one request, answered mem_lat cycles later.
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;
    logic        req_seen;
    logic [31:0] req_a;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5a5a5a5a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample the request at negedge, advance one clock, then update the memory model.
    task automatic cyc();
        @(negedge clk);
        req_seen = (imem_rmask == 4'hf);
        req_a    = imem_addr;
        @(posedge clk);
        #1;
        imem_resp = 1'b0;
        if (req_seen) begin
            mem_cnt  = mem_lat;
            mem_addr = req_a;
        end
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = word_at(mem_addr);
            end
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    logic [31:0] epc;

    initial begin
        rst         = 1'b1;
        imem_resp   = 1'b0;
        imem_rdata  = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        out_ready   = 1'b0;

        // ---- reset values
        cyc();
        cyc();
        settle();
        chk("rst_addr",  {32'd0, imem_addr}, {32'd0, RPC});
        chk("rst_rmask", {60'd0, imem_rmask}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_order", out_order, 64'd0);
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;

        // ---- 1-cycle memory, streaming
        for (int c = 0; c < 8; c++) begin
            settle();
            chk("t1_rmask", {60'd0, imem_rmask}, 64'hf);
            epc = RPC + 32'(4 * c);
            chk("t1_addr", {32'd0, imem_addr}, {32'd0, epc});
            if (c < 2) begin
                chk("t1_valid0", {63'd0, out_valid}, 64'd0);
            end else begin
                epc = RPC + 32'(4 * (c - 2));
                chk("t1_valid", {63'd0, out_valid}, 64'd1);
                chk("t1_pc", {32'd0, out_pc}, {32'd0, epc});
                chk("t1_pcn", {32'd0, out_pc_next}, {32'd0, epc + 32'd4});
                chk("t1_inst", {32'd0, out_inst}, {32'd0, word_at(epc)});
                chk("t1_order", out_order, 64'(c - 2));
            end
            cyc();
        end

        // ---- fill with out_ready=0, then drain
        do_reset(4);
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            settle();
            chk("t2_rmask", {60'd0, imem_rmask}, (c < 4) ? 64'hf : 64'd0);
            chk("t2_valid", {63'd0, out_valid}, (c >= 2) ? 64'd1 : 64'd0);
            if (c >= 2) begin
                chk("t2_head", {32'd0, out_pc}, {32'd0, RPC});
                chk("t2_horder", out_order, 64'd0);
            end
            cyc();
        end
        out_ready = 1'b1;
        for (int c = 7; c < 12; c++) begin
            settle();
            epc = RPC + 32'(4 * (c - 7));
            chk("t2_dvalid", {63'd0, out_valid}, 64'd1);
            chk("t2_dpc", {32'd0, out_pc}, {32'd0, epc});
            chk("t2_dorder", out_order, 64'(c - 7));
            if (c == 7) chk("t2_noissue", {60'd0, imem_rmask}, 64'd0);
            if (c == 8) begin
                chk("t2_resume", {60'd0, imem_rmask}, 64'hf);
                chk("t2_raddr", {32'd0, imem_addr}, {32'd0, RPC + 32'h10});
            end
            cyc();
        end

        // ---- 3-cycle memory
        do_reset(4);
        mem_lat = 3;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("t3_rmask", {60'd0, imem_rmask}, (c % 3 == 0) ? 64'hf : 64'd0);
            if (c % 3 == 0) begin
                epc = RPC + 32'(4 * (c / 3));
                chk("t3_addr", {32'd0, imem_addr}, {32'd0, epc});
            end
            if (c >= 4 && c % 3 == 1) begin
                epc = RPC + 32'(4 * ((c - 4) / 3));
                chk("t3_valid", {63'd0, out_valid}, 64'd1);
                chk("t3_pc", {32'd0, out_pc}, {32'd0, epc});
                chk("t3_order", out_order, 64'((c - 4) / 3));
            end else begin
                chk("t3_valid0", {63'd0, out_valid}, 64'd0);
            end
            cyc();
        end
        // c10: hold the head
        out_ready = 1'b0;
        settle();
        chk("t4_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("t4_hold_pc", {32'd0, out_pc}, {32'd0, RPC + 32'h8});
        cyc();
        // c11: redirect while request 00c is in flight
        redirect    = 1'b1;
        redirect_pc = 32'h1eceb103;
        settle();
        chk("t4_redir_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_redir_rmask", {60'd0, imem_rmask}, 64'd0);
        chk("t4_redir_order", out_order, 64'd2);
        cyc();
        // c12: stale response arrives, new fetch issues
        redirect  = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("t4_new_rmask", {60'd0, imem_rmask}, 64'hf);
        chk("t4_new_addr", {32'd0, imem_addr}, {32'd0, 32'h1eceb100});
        chk("t4_flushed", {63'd0, out_valid}, 64'd0);
        cyc();
        for (int c = 13; c < 15; c++) begin
            settle();
            chk("t4_drop_valid", {63'd0, out_valid}, 64'd0);
            chk("t4_wait_rmask", {60'd0, imem_rmask}, 64'd0);
            cyc();
        end
        settle();
        chk("t4_next_addr", {32'd0, imem_addr}, {32'd0, 32'h1eceb104});
        chk("t4_next_rmask", {60'd0, imem_rmask}, 64'hf);
        cyc();
        settle();
        chk("t4_tgt_valid", {63'd0, out_valid}, 64'd1);
        chk("t4_tgt_pc", {32'd0, out_pc}, {32'd0, 32'h1eceb100});
        chk("t4_tgt_pcn", {32'd0, out_pc_next}, {32'd0, 32'h1eceb104});
        chk("t4_tgt_inst", {32'd0, out_inst}, {32'd0, word_at(32'h1eceb100)});
        chk("t4_tgt_order", out_order, 64'd2);
        cyc();

        // ---- redirect coinciding with imem_resp and out_ready
        do_reset(4);
        mem_lat   = 1;
        out_ready = 1'b1;
        repeat (3) cyc();
        redirect    = 1'b1;
        redirect_pc = 32'h00000200;
        settle();
        chk("t5_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rmask", {60'd0, imem_rmask}, 64'd0);
        chk("t5_order", out_order, 64'd1);
        cyc();
        redirect = 1'b0;
        settle();
        chk("t5_tgt_rmask", {60'd0, imem_rmask}, 64'hf);
        chk("t5_tgt_addr", {32'd0, imem_addr}, {32'd0, 32'h00000200});
        chk("t5_nopush", {63'd0, out_valid}, 64'd0);
        chk("t5_order_kept", out_order, 64'd1);
        cyc();
        settle();
        chk("t5_addr2", {32'd0, imem_addr}, {32'd0, 32'h00000204});
        chk("t5_valid2", {63'd0, out_valid}, 64'd0);
        cyc();
        settle();
        chk("t5_head_pc", {32'd0, out_pc}, {32'd0, 32'h00000200});
        chk("t5_head_inst", {32'd0, out_inst}, {32'd0, word_at(32'h00000200)});
        chk("t5_head_order", out_order, 64'd1);
        mem_lat = 3;
        cyc();
        settle();
        chk("t6_pre_pc", {32'd0, out_pc}, {32'd0, 32'h00000204});
        chk("t6_pre_order", out_order, 64'd2);
        chk("t6_pre_rmask", {60'd0, imem_rmask}, 64'd0);
        cyc();

        // ---- reset mid-stream with request 208 outstanding
        rst = 1'b1;
        settle();
        chk("t6_rst_order_before", out_order, 64'd3);
        cyc();
        rst = 1'b0;
        settle();
        chk("t6_order", out_order, 64'd0);
        chk("t6_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rmask", {60'd0, imem_rmask}, 64'hf);
        chk("t6_addr", {32'd0, imem_addr}, {32'd0, RPC});
        cyc();
        settle();
        chk("t6_late_ignored", {63'd0, out_valid}, 64'd0);
        cyc();
        repeat (2) cyc();
        settle();
        chk("t6_restart_valid", {63'd0, out_valid}, 64'd1);
        chk("t6_restart_pc", {32'd0, out_pc}, {32'd0, RPC});
        chk("t6_restart_inst", {32'd0, out_inst}, {32'd0, word_at(RPC)});
        chk("t6_restart_order", out_order, 64'd0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
